// File: rtl/top_k_drain.sv
// Read-out stage of the top-k chain: snapshots every unit when the end marker leaves
// the last unit, streams the K values (unit 0 first) and then pulses the chain clear.
module top_k_drain #(
  parameter int INTEGER_SIZE = 32,
  parameter int K            = 8,
  parameter int CLEAR_CYCLES = 2*K+2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [K*INTEGER_SIZE-1:0] reg_TDATA,
  input  logic [K-1:0]              reg_TVALID,
  input  logic                      chain_done,
  output logic                      chain_en,
  output logic                      clear_out,
  output logic [INTEGER_SIZE-1:0]   tx_data_TDATA,
  output logic                      tx_data_TVALID,
  output logic                      tx_data_TLAST,
  input  logic                      tx_data_TREADY,
  output logic                      busy,
  output logic                      overrun
);

  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K-1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLEAR_CYCLES-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SEND,
    S_CLEAR
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_idx_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_next;
  logic                      r_overrun;
  logic [K*INTEGER_SIZE-1:0] r_snap;
  logic                      w_send;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (chain_done) begin
          w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_state_next = S_SEND;
        w_idx_next   = '0;
      end
      S_SEND: begin
        if (tx_data_TREADY) begin
          if (r_idx == LAST_IDX) begin
            w_state_next = S_CLEAR;
            w_cnt_next   = CNT_LOAD;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Snapshot is deliberately left out of reset so an abandoned packet's data survives.
  always_ff @(posedge clk) begin
    if (r_state == S_CAPTURE) begin
      for (int i = 0; i < K; i++) begin
        r_snap[i*INTEGER_SIZE +: INTEGER_SIZE] <=
          reg_TVALID[i] ? reg_TDATA[i*INTEGER_SIZE +: INTEGER_SIZE] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (chain_done && (r_state != S_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign w_send         = (r_state == S_SEND);
  assign tx_data_TVALID = w_send;
  assign tx_data_TDATA  = w_send ? r_snap[int'(r_idx)*INTEGER_SIZE +: INTEGER_SIZE] : '0;
  assign tx_data_TLAST  = w_send && (r_idx == LAST_IDX);
  assign busy           = (r_state != S_IDLE);
  assign chain_en       = (r_state == S_IDLE) || (r_state == S_CLEAR);
  // The counter still holds its load value only during the first CLEAR cycle.
  assign clear_out      = (r_state == S_CLEAR) && (r_cnt == CNT_LOAD);
  assign overrun        = r_overrun;

  a_idx_bound: assert property (@(posedge clk) disable iff (!rst_n) r_idx <= LAST_IDX);

  a_axis_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (tx_data_TVALID && !tx_data_TREADY) |=>
      (tx_data_TVALID && $stable(tx_data_TDATA) && $stable(tx_data_TLAST)));

  a_clear_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    (clear_out && (CLEAR_CYCLES > 1)) |=> !clear_out);

endmodule

// File: tb/tb_top_k_drain.sv
// Randomized bench for top_k_drain: a queue-based model predicts every output each cycle,
// with directed packets and a K=1 instance pinned by literal expectations.
module tb_top_k_drain;

  localparam int IS = 32;
  localparam int KK = 4;
  localparam int CC = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [KK*IS-1:0] regData;
  logic [KK-1:0]    regValid;
  logic             chainDone;
  logic             tready;
  logic             chainEn;
  logic             clearOut;
  logic [IS-1:0]    txData;
  logic             txValid;
  logic             txLast;
  logic             busy;
  logic             overrun;

  logic [IS-1:0] data1;
  logic          valid1;
  logic          done1;
  logic          tready1;
  logic          chainEn1;
  logic          clear1;
  logic [IS-1:0] txData1;
  logic          txValid1;
  logic          txLast1;
  logic          busy1;
  logic          overrun1;

  top_k_drain #(.INTEGER_SIZE(IS), .K(KK), .CLEAR_CYCLES(CC)) dut (
    .clk(clk), .rst_n(rst_n), .reg_TDATA(regData), .reg_TVALID(regValid),
    .chain_done(chainDone), .chain_en(chainEn), .clear_out(clearOut),
    .tx_data_TDATA(txData), .tx_data_TVALID(txValid), .tx_data_TLAST(txLast),
    .tx_data_TREADY(tready), .busy(busy), .overrun(overrun)
  );

  top_k_drain #(.INTEGER_SIZE(IS), .K(1), .CLEAR_CYCLES(1)) dutK1 (
    .clk(clk), .rst_n(rst_n), .reg_TDATA(data1), .reg_TVALID(valid1),
    .chain_done(done1), .chain_en(chainEn1), .clear_out(clear1),
    .tx_data_TDATA(txData1), .tx_data_TVALID(txValid1), .tx_data_TLAST(txLast1),
    .tx_data_TREADY(tready1), .busy(busy1), .overrun(overrun1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: mode 0 idle, 1 capture, 2 sending (queue holds words still owed), 3 clearing.
  int          mMode = 0;
  int unsigned mQueue[$];
  int          mClearElapsed = 0;
  bit          mOverrun = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mMode = 0;
      mQueue.delete();
      mClearElapsed = 0;
      mOverrun = 1'b0;
    end else begin
      if (chainDone && mMode != 0) mOverrun = 1'b1;
      case (mMode)
        0: if (chainDone) mMode = 1;
        1: begin
          mQueue.delete();
          for (int i = 0; i < KK; i++)
            mQueue.push_back(regValid[i] ? regData[i*IS +: IS] : 32'd0);
          mMode = 2;
        end
        2: if (tready) begin
          void'(mQueue.pop_front());
          if (mQueue.size() == 0) begin
            mMode = 3;
            mClearElapsed = 0;
          end
        end
        default: begin
          mClearElapsed++;
          if (mClearElapsed == CC) mMode = 0;
        end
      endcase
    end
  end

  bit          cmpEn = 1'b0;
  int unsigned hsLog[$];
  int          clearCount = 0;

  always @(negedge clk) begin
    if (cmpEn) begin
      logic [31:0] expData;
      expData = (mMode == 2 && mQueue.size() > 0) ? mQueue[0] : 32'd0;
      checkOutput("tvalid", txValid, (mMode == 2));
      checkOutput("tdata", txData, expData);
      checkOutput("tlast", txLast, (mMode == 2 && mQueue.size() == 1));
      checkOutput("busy", busy, (mMode != 0));
      checkOutput("chain_en", chainEn, (mMode == 0 || mMode == 3));
      checkOutput("clear_out", clearOut, (mMode == 3 && mClearElapsed == 0));
      checkOutput("overrun", overrun, mOverrun);
    end
    if (txValid && tready) hsLog.push_back(txData);
    if (clearOut) clearCount++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle(input string name, input int maxC, output int n);
    n = 0;
    while (busy && n < maxC) begin
      tick();
      n++;
    end
    checkOutput({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic checkPacket(input string name, input int unsigned e0, input int unsigned e1,
                             input int unsigned e2, input int unsigned e3);
    int unsigned exp4[4];
    exp4 = '{e0, e1, e2, e3};
    checkOutput({name, "_count"}, hsLog.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s_word%0d", name, i),
                  (i < hsLog.size()) ? hsLog[i] : 32'hBAD0BAD0, exp4[i]);
  endtask

  task automatic applyStimulus(input logic [KK*IS-1:0] data, input logic [KK-1:0] valid);
    regData   = data;
    regValid  = valid;
    chainDone = 1'b1;
    tick();
    chainDone = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; regData = '0; regValid = '0; chainDone = 1'b0; tready = 1'b1;
    data1 = '0; valid1 = 1'b0; done1 = 1'b0; tready1 = 1'b1;
    repeat (3) tick();
    checkOutput("rst_tvalid", txValid, 1'b0);
    checkOutput("rst_tdata", txData, 32'd0);
    checkOutput("rst_chain_en", chainEn, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    cmpEn = 1'b1;

    $display("[TB] basic packet, TREADY high");
    hsLog.delete(); clearCount = 0;
    applyStimulus({32'd3, 32'd7, 32'd40, 32'd90}, 4'hF);
    checkOutput("t1_capture_busy", busy, 1'b1);
    checkOutput("t1_capture_en", chainEn, 1'b0);
    checkOutput("t1_capture_tvalid", txValid, 1'b0);
    tick();
    checkOutput("t1_first_tvalid", txValid, 1'b1);
    checkOutput("t1_first_word", txData, 32'd90);
    waitIdle("t1", 60, n);
    checkOutput("t1_idle_delay", n, 14);
    checkOutput("t1_clear_pulses", clearCount, 1);
    checkPacket("t1", 90, 40, 7, 3);

    $display("[TB] TREADY toggling");
    hsLog.delete();
    applyStimulus({32'd3, 32'd7, 32'd40, 32'd90}, 4'hF);
    tick();
    for (int i = 0; busy && i < 60; i++) begin
      tready = pat[i % 4];
      tick();
    end
    tready = 1'b1;
    checkPacket("t2", 90, 40, 7, 3);

    $display("[TB] partial valid");
    hsLog.delete();
    applyStimulus({$urandom(), $urandom(), 32'd12, 32'd55}, 4'b0011);
    waitIdle("t3", 60, n);
    checkPacket("t3", 55, 12, 0, 0);

    $display("[TB] data change and overrun during SEND");
    hsLog.delete();
    applyStimulus({32'd40, 32'd30, 32'd20, 32'd10}, 4'hF);
    tick();
    regData = {KK{32'hFFFF_FFFF}};
    chainDone = 1'b1;
    tick();
    chainDone = 1'b0;
    checkOutput("t4_overrun_set", overrun, 1'b1);
    waitIdle("t4a", 60, n);
    checkPacket("t4a", 10, 20, 30, 40);
    hsLog.delete();
    applyStimulus({KK{32'hFFFF_FFFF}}, 4'hF);
    waitIdle("t4b", 60, n);
    checkPacket("t4b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("t4_overrun_sticky", overrun, 1'b1);

    $display("[TB] reset mid-packet");
    hsLog.delete();
    applyStimulus({32'd8, 32'd7, 32'd6, 32'd5}, 4'hF);
    for (int i = 0; hsLog.size() < 2 && i < 20; i++) tick();
    checkOutput("t5_two_handshakes", hsLog.size(), 2);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_tvalid", txValid, 1'b0);
    checkOutput("t5_rst_tlast", txLast, 1'b0);
    checkOutput("t5_rst_clear", clearOut, 1'b0);
    checkOutput("t5_rst_busy", busy, 1'b0);
    checkOutput("t5_rst_chain_en", chainEn, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    hsLog.delete();
    applyStimulus({32'd4, 32'd3, 32'd2, 32'd1}, 4'hF);
    waitIdle("t5", 60, n);
    checkPacket("t5", 1, 2, 3, 4);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 2000; c++) begin
      chainDone = ($urandom_range(0, 24) == 0);
      tready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < KK; i++) regData[i*IS +: IS] = $urandom();
        regValid = KK'($urandom());
      end
      tick();
    end
    chainDone = 1'b0;
    tready = 1'b1;
    waitIdle("rand", 60, n);

    $display("[TB] K=1 instance");
    data1 = 32'hDEAD_BEEF; valid1 = 1'b1; done1 = 1'b1;
    tick();
    done1 = 1'b0;
    checkOutput("k1_capture_busy", busy1, 1'b1);
    checkOutput("k1_capture_tvalid", txValid1, 1'b0);
    tick();
    checkOutput("k1_tvalid", txValid1, 1'b1);
    checkOutput("k1_tdata", txData1, 32'hDEAD_BEEF);
    checkOutput("k1_tlast", txLast1, 1'b1);
    tick();
    checkOutput("k1_clear", clear1, 1'b1);
    checkOutput("k1_clear_en", chainEn1, 1'b1);
    checkOutput("k1_clear_tvalid", txValid1, 1'b0);
    tick();
    checkOutput("k1_idle_busy", busy1, 1'b0);
    checkOutput("k1_idle_clear", clear1, 1'b0);
    valid1 = 1'b0; done1 = 1'b1;
    tick();
    done1 = 1'b0;
    tick();
    checkOutput("k1_invalid_tdata", txData1, 32'd0);
    checkOutput("k1_invalid_tlast", txLast1, 1'b1);
    repeat (3) tick();
    checkOutput("k1_overrun", overrun1, 1'b0);

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
